wb_target_mem: RTL and testbench
================================

WB_TARGET_MEM -- requirements
Module: wb_target_mem

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data bus width in bits; only 32 is supported.
REQ-002 Parameter ADDR_WIDTH, default 32, byte-address bus width.
REQ-003 Parameter DEPTH, default 256, memory size in words (power of 2).
REQ-004 Parameter WAIT_STATES, default 1, extra cycles before response (range 0..15).
REQ-005 clock  input  1  clock; all state changes on the rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 cyc  input  1  initiator request, held until ack/err is sampled.
REQ-008 adr  input  ADDR_WIDTH  byte address.
REQ-009 dat_w  input  DATA_WIDTH  write data.
REQ-010 we  input  1  1=write, 0=read.
REQ-011 sel  input  4  byte-lane enables; sel[i] gates dat_w[8i+7:8i].
REQ-012 ack  output  1  one-cycle successful-completion pulse.
REQ-013 err  output  1  one-cycle error-completion pulse.
REQ-014 dat_r  output  DATA_WIDTH  read data, valid while ack=1.
REQ-015 txn_count  output  16  completed-ack count, wraps at 0xFFFF->0.
REQ-016 err_count  output  16  completed-err count, wraps at 0xFFFF->0.

Function
REQ-017 FSM states: IDLE, WAIT, RESP, DONE.
REQ-018 IDLE, cyc=1: latch adr, dat_w, we, sel; go to WAIT with wait counter=WAIT_STATES, or to RESP directly when WAIT_STATES=0.
REQ-019 WAIT: counter decrements by 1 per cycle; go to RESP when it reaches 1 (or immediately if already 0).
REQ-020 Latency: ack/err go high exactly WAIT_STATES+1 cycles after the edge that first samples cyc=1 in IDLE.
REQ-021 RESP: exactly one of ack/err is 1 for exactly one cycle; then go to DONE.
REQ-022 DONE: ack=err=0; stay until cyc=0, then go to IDLE; no new request is accepted before cyc has been sampled low.
REQ-023 Error condition: adr[1:0]!=0, or word index adr>>2 >= DEPTH; result is err=1, ack=0, no memory write, dat_r=0.
REQ-024 Write with no error: on the edge entering RESP, memory[adr>>2] updates only in lanes where sel=1; other lanes are unchanged; sel=0 is legal and gives ack with no change.
REQ-025 Read with no error: dat_r=memory[adr>>2] for all lanes regardless of sel, presented in the RESP cycle; dat_r=0 in all other states.
REQ-026 cyc dropped to 0 in WAIT (abort): go to IDLE next edge, no write, no ack/err, counters unchanged.
REQ-027 Inputs are sampled only in IDLE; changes to adr/dat_w/we/sel during WAIT/RESP/DONE have no effect.
REQ-028 txn_count increments on every ack cycle; err_count increments on every err cycle.

Reset
REQ-029 Reset forces state=IDLE, ack=0, err=0, dat_r=0, txn_count=0, err_count=0, wait counter=0 asynchronously.
REQ-030 Memory contents are not cleared by reset and are preserved across it.
REQ-031 Reset during WAIT/RESP/DONE aborts the transfer: no write commits unless the RESP-entry edge preceded reset assertion.
REQ-032 First request after reset release is accepted on the first edge with reset=0 and cyc=1.

Structure
REQ-033 Package wb_target_pkg holds the FSM state enum, lane count (4), and the counter width (16).
REQ-034 Sub-module wb_target_ram holds the byte-lane-enabled single-port RAM (DEPTH x 32, 4 write enables, combinational read).
REQ-035 wb_target_mem contains the FSM, address decode/error check, wait counter and status counters.

Verification
REQ-036 Write adr=0x10, dat_w=0xDEADBEEF, sel=0xF, WAIT_STATES=1; then read 0x10 -> ack 2 cycles after cyc, dat_r=0xDEADBEEF, txn_count=2.
REQ-037 Over it, write adr=0x10, dat_w=0x11223344, sel=0x5; read -> dat_r=0xDE22BE44.
REQ-038 Read adr=0x12 (misaligned) and adr=0x400 (DEPTH=256) -> err pulse each, ack=0, err_count=2, memory unchanged.
REQ-039 cyc=1 held 3 cycles after ack -> single ack pulse only; next request accepted only after cyc=0 is sampled.
REQ-040 WAIT_STATES=3, drop cyc one cycle into WAIT on a write of 0xCAFEF00D to 0x20 -> no ack/err; later read 0x20 returns the prior value.
REQ-041 Assert reset in WAIT, then release and read -> outputs and counters 0 during reset; memory contents earlier written survive.

Source files
------------

// File: rtl/wb_target_pkg.sv
// Shared types and constants for the Wishbone-style memory target:
// FSM state encoding, byte-lane count, counter widths and lane helpers.
package wb_target_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int LANES  = 4;
    localparam int CNT_W  = 16;
    localparam int WCNT_W = 4;

    // Per-lane write strobes: the byte selects, or nothing when no write is due.
    function automatic logic [LANES-1:0] lane_we(input logic en, input logic [LANES-1:0] sel);
        logic [LANES-1:0] strobes;
        if (en) begin
            strobes = sel;
        end else begin
            strobes = {LANES{1'b0}};
        end
        return strobes;
    endfunction

endpackage

// File: rtl/wb_target_mem_if.sv
// Bus bundle between an initiator and the memory target.
interface wb_target_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic                             cyc;
    logic [ADDR_WIDTH-1:0]            adr;
    logic [DATA_WIDTH-1:0]            dat_w;
    logic                             we;
    logic [wb_target_pkg::LANES-1:0]  sel;
    logic                             ack;
    logic                             err;
    logic [DATA_WIDTH-1:0]            dat_r;

    modport master (
        output cyc, adr, dat_w, we, sel,
        input  ack, err, dat_r
    );

    modport slave (
        input  cyc, adr, dat_w, we, sel,
        output ack, err, dat_r
    );

endinterface

// File: rtl/wb_target_ram.sv
// Single-port word RAM with per-byte write enables and combinational read.
// Contents are deliberately not reset so they survive a target reset.
module wb_target_ram
    import wb_target_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic [LANES-1:0] wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [DEPTH];

    // Byte-lane gated write; unselected lanes keep their old contents.
    always_ff @(posedge clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_en[i]) begin
                mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/wb_target_mem.sv
// Wishbone-style memory target: accepts one request at a time, inserts a
// programmable number of wait states, answers with a single ack or err
// pulse and keeps running completion/error counters.
module wb_target_mem
    import wb_target_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic              clock,
    input  logic              reset,
    wb_target_mem_if.slave    bus,
    output logic [CNT_W-1:0]  txn_count,
    output logic [CNT_W-1:0]  err_count
);

    localparam int                    AW      = $clog2(DEPTH);
    localparam logic [WCNT_W-1:0]     WS_INIT = WCNT_W'(WAIT_STATES);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(DEPTH);

    // Misaligned byte addresses and word indices past the array are errors.
    function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[ADDR_WIDTH-1:2]} >= DEPTH_W);
    endfunction

    state_e                 state_q,  state_d;
    logic [WCNT_W-1:0]      wcnt_q,   wcnt_d;
    logic [ADDR_WIDTH-1:0]  adr_q,    adr_d;
    logic [DATA_WIDTH-1:0]  dat_w_q,  dat_w_d;
    logic                   we_q,     we_d;
    logic [LANES-1:0]       sel_q,    sel_d;
    logic                   ack_q,    ack_d;
    logic                   err_q,    err_d;
    logic [DATA_WIDTH-1:0]  dat_r_q,  dat_r_d;
    logic [CNT_W-1:0]       txn_q,    txn_d;
    logic [CNT_W-1:0]       errc_q,   errc_d;

    // The request in flight: live bus fields while idle (zero-wait-state
    // path), the latched copy afterwards.
    logic [ADDR_WIDTH-1:0]  req_adr_s;
    logic [DATA_WIDTH-1:0]  req_dat_s;
    logic                   req_we_s;
    logic [LANES-1:0]       req_sel_s;
    logic                   bad_s;
    logic                   enter_resp_s;
    logic [LANES-1:0]       ram_we_s;
    logic [31:0]            ram_rdata_s;

    wb_target_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clock (clock),
        .wr_en (ram_we_s),
        .addr  (req_adr_s[AW+1:2]),
        .wdata (req_dat_s),
        .rdata (ram_rdata_s)
    );

    // Next-state, wait-counter, response and counter logic.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        adr_d        = adr_q;
        dat_w_d      = dat_w_q;
        we_d         = we_q;
        sel_d        = sel_q;
        enter_resp_s = 1'b0;

        if (state_q == ST_IDLE) begin
            req_adr_s = bus.adr;
            req_dat_s = bus.dat_w;
            req_we_s  = bus.we;
            req_sel_s = bus.sel;
        end else begin
            req_adr_s = adr_q;
            req_dat_s = dat_w_q;
            req_we_s  = we_q;
            req_sel_s = sel_q;
        end
        bad_s = addr_bad(req_adr_s);

        case (state_q)
            ST_IDLE: begin
                if (bus.cyc) begin
                    adr_d   = bus.adr;
                    dat_w_d = bus.dat_w;
                    we_d    = bus.we;
                    sel_d   = bus.sel;
                    if (WS_INIT == 4'd0) begin
                        state_d      = ST_RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        wcnt_d  = WS_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!bus.cyc) begin
                    // Initiator gave up: drop the request without side effects.
                    state_d = ST_IDLE;
                    wcnt_d  = 4'd0;
                end else if (wcnt_q <= 4'd1) begin
                    state_d      = ST_RESP;
                    enter_resp_s = 1'b1;
                    wcnt_d       = 4'd0;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!bus.cyc) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                wcnt_d  = 4'd0;
            end
        endcase

        // Response, write strobe and read data are all decided on RESP entry.
        ram_we_s = lane_we(enter_resp_s && !bad_s && req_we_s, req_sel_s);
        if (enter_resp_s) begin
            ack_d = !bad_s;
            err_d = bad_s;
        end else begin
            ack_d = 1'b0;
            err_d = 1'b0;
        end
        if (enter_resp_s && !bad_s && !req_we_s) begin
            dat_r_d = ram_rdata_s;
        end else begin
            dat_r_d = {DATA_WIDTH{1'b0}};
        end

        if (ack_q) begin
            txn_d = txn_q + 16'd1;
        end else begin
            txn_d = txn_q;
        end
        if (err_q) begin
            errc_d = errc_q + 16'd1;
        end else begin
            errc_d = errc_q;
        end
    end

    // State and registered outputs, cleared asynchronously by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 4'd0;
            adr_q   <= {ADDR_WIDTH{1'b0}};
            dat_w_q <= {DATA_WIDTH{1'b0}};
            we_q    <= 1'b0;
            sel_q   <= {LANES{1'b0}};
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_r_q <= {DATA_WIDTH{1'b0}};
            txn_q   <= 16'd0;
            errc_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            adr_q   <= adr_d;
            dat_w_q <= dat_w_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_r_q <= dat_r_d;
            txn_q   <= txn_d;
            errc_q  <= errc_d;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.dat_r = dat_r_q;
    assign txn_count = txn_q;
    assign err_count = errc_q;

endmodule

// File: tb/tb_wb_target_mem.sv
// Bench for wb_target_mem: two targets (1 and 3 wait states) driven by
// directed scenarios and random traffic, checked against a word-array model.
module tb_wb_target_mem;

    localparam int DEPTH = 256;

    logic clock = 1'b0;
    logic reset;

    wb_target_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b0 ();
    wb_target_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b1 ();

    logic [15:0] txn0, err0, txn1, err1;

    wb_target_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(1)) u0 (
        .clock(clock), .reset(reset), .bus(b0), .txn_count(txn0), .err_count(err0));
    wb_target_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(3)) u1 (
        .clock(clock), .reset(reset), .bus(b1), .txn_count(txn1), .err_count(err1));

    always #5 clock = ~clock;

    // reference model
    logic [31:0] mem_m [2][DEPTH];
    int m_txn [2];
    int m_err [2];

    int n_pass  = 0;
    int n_total = 0;

    function automatic int ws_of(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    task automatic drive(input int u, input logic c, input logic [31:0] a, input logic [31:0] d,
                         input logic w, input logic [3:0] s);
        if (u == 0) begin
            b0.cyc = c; b0.adr = a; b0.dat_w = d; b0.we = w; b0.sel = s;
        end else begin
            b1.cyc = c; b1.adr = a; b1.dat_w = d; b1.we = w; b1.sel = s;
        end
    endtask

    task automatic sample(input int u, output logic ack, output logic err, output logic [31:0] dr,
                          output logic [15:0] tc, output logic [15:0] ec);
        if (u == 0) begin
            ack = b0.ack; err = b0.err; dr = b0.dat_r; tc = txn0; ec = err0;
        end else begin
            ack = b1.ack; err = b1.err; dr = b1.dat_r; tc = txn1; ec = err1;
        end
    endtask

    // One full transfer starting at a negedge with the target idle; ends idle at a negedge.
    task automatic txn(input int u, input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, input int hold, input string tag, output logic [31:0] rd_obs);
        logic        e_bad, ack, err;
        logic [31:0] e_rd, dr;
        logic [15:0] tc, ec;
        int          lat, widx;
        widx  = int'(a >> 2);
        e_bad = (a % 4 != 0) || (widx >= DEPTH);
        e_rd  = 32'h0;
        if (!e_bad && !w) e_rd = mem_m[u][widx];
        lat    = ws_of(u) + 1;
        rd_obs = 32'h0;
        drive(u, 1'b1, a, d, w, s);
        for (int n = 1; n <= lat; n++) begin
            @(posedge clock);
            if (n == 1) begin
                #1 drive(u, 1'b1, $urandom(), $urandom(), 1'($urandom()), 4'($urandom()));
            end
            @(negedge clock);
            sample(u, ack, err, dr, tc, ec);
            if (n < lat) begin
                n_total++;
                if (ack !== 1'b0 || err !== 1'b0 || dr !== 32'h0)
                    $display("FAIL %s early_resp u=%0d cyc=%0d ack=%b err=%b dat_r=%h expected 0 0 0",
                             tag, u, n, ack, err, dr);
                else n_pass++;
            end else begin
                rd_obs = dr;
                n_total++;
                if (ack !== !e_bad || err !== e_bad)
                    $display("FAIL %s resp u=%0d adr=%h ack=%b err=%b expected ack=%b err=%b",
                             tag, u, a, ack, err, !e_bad, e_bad);
                else n_pass++;
                if (!w || e_bad) begin
                    n_total++;
                    if (dr !== e_rd)
                        $display("FAIL %s dat_r u=%0d adr=%h got %h expected %h", tag, u, a, dr, e_rd);
                    else n_pass++;
                end
            end
        end
        if (!e_bad) begin
            if (w) begin
                for (int l = 0; l < 4; l++)
                    if (s[l]) mem_m[u][widx][8*l +: 8] = d[8*l +: 8];
            end
            m_txn[u]++;
        end else begin
            m_err[u]++;
        end
        // keep cyc high and offer a fresh write; the target must not take it
        for (int h = 0; h < hold; h++) begin
            @(posedge clock);
            #1 drive(u, 1'b1, 32'h3C, $urandom(), 1'b1, 4'hF);
            @(negedge clock);
            sample(u, ack, err, dr, tc, ec);
            n_total++;
            if (ack !== 1'b0 || err !== 1'b0 || dr !== 32'h0)
                $display("FAIL %s hold u=%0d h=%0d ack=%b err=%b dat_r=%h expected 0 0 0", tag, u, h, ack, err, dr);
            else n_pass++;
        end
        @(posedge clock);
        #1 drive(u, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        @(negedge clock);
        sample(u, ack, err, dr, tc, ec);
        n_total++;
        if (ack !== 1'b0 || err !== 1'b0)
            $display("FAIL %s single_pulse u=%0d ack=%b err=%b expected 0 0", tag, u, ack, err);
        else n_pass++;
        @(posedge clock);
        @(negedge clock);
        sample(u, ack, err, dr, tc, ec);
        n_total++;
        if (tc !== 16'(m_txn[u]) || ec !== 16'(m_err[u]))
            $display("FAIL %s counters u=%0d txn=%0d err=%0d expected %0d %0d", tag, u, tc, ec, m_txn[u], m_err[u]);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic ack, err; logic [31:0] dr; logic [15:0] tc, ec;
        for (int u = 0; u < 2; u++) begin
            sample(u, ack, err, dr, tc, ec);
            n_total++;
            if (ack !== 1'b0 || err !== 1'b0 || dr !== 32'h0 || tc !== 16'h0 || ec !== 16'h0)
                $display("FAIL reset_state u=%0d ack=%b err=%b dat_r=%h txn=%0d err=%0d expected all 0",
                         u, ack, err, dr, tc, ec);
            else n_pass++;
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        txn(0, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 0, "wr_full", rd);
        txn(0, 32'h10, 1'b0, 32'h0, 4'h0, 0, "rd_full", rd);
        n_total++;
        if (rd !== 32'hDEADBEEF || txn0 !== 16'd2)
            $display("FAIL rd_full_const dat_r=%h txn=%0d expected DEADBEEF 2", rd, txn0);
        else n_pass++;
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        txn(0, 32'h10, 1'b1, 32'h11223344, 4'h5, 0, "wr_lanes", rd);
        txn(0, 32'h10, 1'b0, 32'h0, 4'h0, 0, "rd_lanes", rd);
        n_total++;
        if (rd !== 32'hDE22BE44)
            $display("FAIL rd_lanes_const dat_r=%h expected DE22BE44", rd);
        else n_pass++;
        txn(0, 32'h10, 1'b1, 32'hFFFFFFFF, 4'h0, 0, "wr_nosel", rd);
        txn(0, 32'h10, 1'b0, 32'h0, 4'hF, 0, "rd_nosel", rd);
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        txn(0, 32'h12, 1'b0, 32'h0, 4'hF, 0, "err_misaligned", rd);
        txn(0, 32'h400, 1'b0, 32'h0, 4'hF, 0, "err_range", rd);
        n_total++;
        if (err0 !== 16'd2)
            $display("FAIL err_count_const got %0d expected 2", err0);
        else n_pass++;
        txn(0, 32'h13, 1'b1, 32'h0, 4'hF, 0, "err_wr_misaligned", rd);
        txn(0, 32'h10, 1'b0, 32'h0, 4'hF, 0, "rd_after_err", rd);
    endtask

    task automatic test_hold();
        logic [31:0] rd;
        txn(0, 32'h3C, 1'b1, 32'h5A5A5A5A, 4'hF, 0, "hold_setup", rd);
        txn(0, 32'h10, 1'b0, 32'h0, 4'hF, 3, "hold_rd", rd);
        txn(0, 32'h3C, 1'b0, 32'h0, 4'hF, 0, "hold_check", rd);
    endtask

    task automatic test_abort();
        logic        ack, err;
        logic [31:0] rd, dr;
        logic [15:0] tc, ec;
        txn(1, 32'h20, 1'b1, 32'h01234567, 4'hF, 0, "abort_setup", rd);
        drive(1, 1'b1, 32'h20, 32'hCAFEF00D, 1'b1, 4'hF);
        @(posedge clock);
        @(negedge clock);
        drive(1, 1'b0, 32'h20, 32'hCAFEF00D, 1'b1, 4'hF);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            sample(1, ack, err, dr, tc, ec);
            n_total++;
            if (ack !== 1'b0 || err !== 1'b0)
                $display("FAIL abort_resp i=%0d ack=%b err=%b expected 0 0", i, ack, err);
            else n_pass++;
        end
        n_total++;
        if (tc !== 16'(m_txn[1]) || ec !== 16'(m_err[1]))
            $display("FAIL abort_counters txn=%0d err=%0d expected %0d %0d", tc, ec, m_txn[1], m_err[1]);
        else n_pass++;
        txn(1, 32'h20, 1'b0, 32'h0, 4'hF, 0, "abort_rd", rd);
    endtask

    task automatic test_reset_mid();
        logic        ack, err;
        logic [31:0] rd, dr;
        logic [15:0] tc, ec;
        txn(0, 32'h14, 1'b1, 32'h600DF00D, 4'hF, 0, "rst_setup", rd);
        drive(0, 1'b1, 32'h14, 32'hBAADBAAD, 1'b1, 4'hF);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        m_txn[0] = 0; m_err[0] = 0; m_txn[1] = 0; m_err[1] = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            for (int u = 0; u < 2; u++) begin
                sample(u, ack, err, dr, tc, ec);
                n_total++;
                if (ack !== 1'b0 || err !== 1'b0 || dr !== 32'h0 || tc !== 16'h0 || ec !== 16'h0)
                    $display("FAIL reset_mid u=%0d ack=%b err=%b dat_r=%h txn=%0d err=%0d expected all 0",
                             u, ack, err, dr, tc, ec);
                else n_pass++;
            end
            @(negedge clock);
        end
        reset = 1'b0;
        txn(0, 32'h14, 1'b0, 32'h0, 4'hF, 0, "rst_rd_aborted", rd);
        txn(0, 32'h10, 1'b0, 32'h0, 4'hF, 0, "rst_rd_survive", rd);
    endtask

    task automatic test_random();
        logic [31:0] rd, a;
        int          u, kind;
        for (int u2 = 0; u2 < 2; u2++)
            for (int i = 0; i < 16; i++)
                txn(u2, 32'(i * 4), 1'b1, $urandom(), 4'hF, 0, "fill", rd);
        for (int k = 0; k < 40; k++) begin
            u    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            if (kind == 0)      a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            else if (kind == 1) a = (32'd256 + 32'($urandom_range(0, 4095))) << 2;
            else                a = 32'($urandom_range(0, 15)) << 2;
            txn(u, a, 1'($urandom()), $urandom(), 4'($urandom()), int'($urandom_range(0, 1)), "random", rd);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        drive(1, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        m_txn[0] = 0; m_err[0] = 0; m_txn[1] = 0; m_err[1] = 0;
        #1;
        test_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        test_write_read();
        test_byte_lanes();
        test_errors();
        test_hold();
        test_abort();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end

endmodule
